instr_decode_stage: RTL and testbench

Registered decode stage between instruction fetch and the immediate sign-extender / register-file read.
- Accepts 32-bit RV32 instructions over a valid/ready handshake.
- Splits each instruction into fields and assembles the 12-bit immediate (I/S formats) consumed by the downstream 12→32 sign-extension stage.
- A 2-entry skid buffer gives full throughput under downstream backpressure. Flush support covers branch redirect.

---
 rtl/instr_decode_stage_pkg.sv | 46 ++++
 rtl/instr_decode_stage_decode_fields.sv | 55 +++++
 rtl/instr_decode_stage.sv | 132 +++++++++++++
 tb/tb_instr_decode_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_decode_stage_pkg.sv
// Shared definitions for the instruction decode stage.
// Holds RV32 opcode constants, instruction field widths, the occupancy
// state encoding of the two-entry buffer, and the registered field bundle.
// Optional feature macro: DECODE_ILLEGAL_CHECK_EN (adds the illegal flag).
package instr_decode_stage_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned FUNCT3_W = 3;
  localparam int unsigned FUNCT7_W = 7;
  localparam int unsigned IMM12_W  = 12;

  localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OP_SYSTEM = 7'b1110011;

  // Buffer occupancy: nothing held, main register only, main plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_t;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rd;
    logic [FUNCT3_W-1:0] funct3;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
    logic [FUNCT7_W-1:0] funct7;
    logic [IMM12_W-1:0]  imm12;
    logic                is_store;
`ifdef DECODE_ILLEGAL_CHECK_EN
    logic                illegal;
`endif
  } dec_t;

endpackage

// File: rtl/instr_decode_stage_decode_fields.sv
// Combinational RV32 instruction -> field / 12-bit immediate extraction.
// Ports:
//   instr    : raw 32-bit instruction
//   opcode, rd, funct3, rs1, rs2, funct7 : raw fields
//   imm12    : I-type instr[31:20], S-type {instr[31:25], instr[11:7]}, else 0
//   is_store : opcode is S-type
//   illegal  : (DECODE_ILLEGAL_CHECK_EN only) non-32-bit encoding or unknown opcode
module instr_decode_stage_decode_fields
  import instr_decode_stage_pkg::*;
(
  input  logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  funct7,
  output logic [11:0] imm12,
  output logic        is_store
`ifdef DECODE_ILLEGAL_CHECK_EN
  ,output logic       illegal
`endif
);

  always_comb begin
    opcode   = instr[6:0];
    rd       = instr[11:7];
    funct3   = instr[14:12];
    rs1      = instr[19:15];
    rs2      = instr[24:20];
    funct7   = instr[31:25];
    imm12    = '0;
    is_store = 1'b0;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR: imm12 = instr[31:20];
      OP_STORE: begin
        imm12    = {instr[31:25], instr[11:7]};
        is_store = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef DECODE_ILLEGAL_CHECK_EN
  always_comb begin
    illegal = (instr[1:0] != 2'b11);
    case (instr[6:0])
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: ;
      default: illegal = 1'b1;
    endcase
  end
`endif

endmodule

// File: rtl/instr_decode_stage.sv
// Registered RV32 decode stage with a two-entry (main + skid) buffer.
// Optional feature macro: DECODE_ILLEGAL_CHECK_EN adds out_illegal.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : fetch handshake, in_instr raw word
//   flush                : synchronous discard of all buffered words
//   out_valid/out_ready  : consumer handshake
//   out_opcode..out_funct7, out_imm12, out_is_store : decoded fields
//   out_illegal          : (optional) unknown/non-32-bit encoding flag
module instr_decode_stage
  import instr_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned IMM_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_funct3,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [6:0]       out_funct7,
  output logic [IMM_W-1:0] out_imm12,
  output logic             out_is_store
`ifdef DECODE_ILLEGAL_CHECK_EN
  ,output logic            out_illegal
`endif
);

  occ_state_t state_q, state_d;
  dec_t       dec_new, main_q, skid_q;
  logic       in_xfer, out_xfer;
  logic       load_main_new, load_main_skid, load_skid;

  instr_decode_stage_decode_fields u_decode_fields (
    .instr    (in_instr),
    .opcode   (dec_new.opcode),
    .rd       (dec_new.rd),
    .funct3   (dec_new.funct3),
    .rs1      (dec_new.rs1),
    .rs2      (dec_new.rs2),
    .funct7   (dec_new.funct7),
    .imm12    (dec_new.imm12),
    .is_store (dec_new.is_store)
`ifdef DECODE_ILLEGAL_CHECK_EN
    ,.illegal (dec_new.illegal)
`endif
  );

  // Handshake flags come straight from the state register, so in_ready
  // never depends combinationally on out_ready.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          load_main_new = 1'b1;
          state_d       = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          load_main_new = 1'b1;
        end else if (in_xfer) begin
          load_skid = 1'b1;
          state_d   = ST_FULL;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          load_main_skid = 1'b1;
          state_d        = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush overrides everything: any same-cycle input is dropped, and an
    // output handshake in that cycle has already delivered its word.
    if (flush) begin
      state_d        = ST_EMPTY;
      load_main_new  = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_new)       main_q <= dec_new;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= dec_new;
    end
  end

  assign out_opcode   = main_q.opcode;
  assign out_rd       = main_q.rd;
  assign out_funct3   = main_q.funct3;
  assign out_rs1      = main_q.rs1;
  assign out_rs2      = main_q.rs2;
  assign out_funct7   = main_q.funct7;
  assign out_imm12    = main_q.imm12;
  assign out_is_store = main_q.is_store;
`ifdef DECODE_ILLEGAL_CHECK_EN
  assign out_illegal  = main_q.illegal;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: directed steps followed by
// random traffic, checked against a FIFO reference model (queue of raw words,
// fields re-derived from the RV32 encoding rules).
// Optional feature macro: DECODE_ILLEGAL_CHECK_EN (checks out_illegal too).
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [6:0]  out_funct7;
  logic [11:0] out_imm12;
  logic        out_is_store;
`ifdef DECODE_ILLEGAL_CHECK_EN
  logic        out_illegal;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned popped = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  instr_decode_stage #(.XLEN(32), .IMM_W(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_opcode   (out_opcode),
    .out_rd       (out_rd),
    .out_funct3   (out_funct3),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2),
    .out_funct7   (out_funct7),
    .out_imm12    (out_imm12),
    .out_is_store (out_is_store)
`ifdef DECODE_ILLEGAL_CHECK_EN
    ,.out_illegal (out_illegal)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ref_imm(input logic [31:0] i);
    if (i[6:0] == 7'b0010011 || i[6:0] == 7'b0000011 || i[6:0] == 7'b1100111)
      return i[31:20];
    if (i[6:0] == 7'b0100011)
      return {i[31:25], i[11:7]};
    return 12'h000;
  endfunction

  function automatic logic ref_illegal(input logic [31:0] i);
    return (i[1:0] != 2'b11) ||
           !(i[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011});
  endfunction

  task automatic check_front();
    logic [31:0] i;
    i = q[0];
    check("opcode", 32'(out_opcode), 32'(i[6:0]));
    check("rd", 32'(out_rd), 32'(i[11:7]));
    check("funct3", 32'(out_funct3), 32'(i[14:12]));
    check("rs1", 32'(out_rs1), 32'(i[19:15]));
    check("rs2", 32'(out_rs2), 32'(i[24:20]));
    check("funct7", 32'(out_funct7), 32'(i[31:25]));
    check("imm12", 32'(out_imm12), 32'(ref_imm(i)));
    check("is_store", 32'(out_is_store), 32'(i[6:0] == 7'b0100011));
`ifdef DECODE_ILLEGAL_CHECK_EN
    check("illegal", 32'(out_illegal), 32'(ref_illegal(i)));
`endif
  endtask

  // One clock cycle: entered and left 1 time unit after a rising edge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    logic exp_ir, exp_ov;
    in_valid  = v;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    #3;
    exp_ir = (q.size() < 2);
    exp_ov = (q.size() > 0);
    check("in_ready", 32'(in_ready), 32'(exp_ir));
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) check_front();
    @(posedge clk);
    if (exp_ov && ordy) begin
      void'(q.pop_front());
      popped++;
    end
    if (fl) q.delete();
    else if (v && exp_ir) q.push_back(ins);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 11))
      0: r[6:0] = 7'b0110011;
      1: r[6:0] = 7'b0010011;
      2: r[6:0] = 7'b0000011;
      3: r[6:0] = 7'b0100011;
      4: r[6:0] = 7'b1100011;
      5: r[6:0] = 7'b1101111;
      6: r[6:0] = 7'b1100111;
      7: r[6:0] = 7'b0110111;
      8: r[6:0] = 7'b0010111;
      9: r[6:0] = 7'b1110011;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    int unsigned p0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_imm12", 32'(out_imm12), 32'd0);
    check("rst_opcode", 32'(out_opcode), 32'd0);
    rst_n = 1'b1;

    // addi x1,x2,-1 then sw x5,8(x2)
    cycle(1'b1, 32'hFFF10093, 1'b1, 1'b0);
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_opcode", 32'(out_opcode), 32'h13);
    check("addi_rd", 32'(out_rd), 32'd1);
    check("addi_rs1", 32'(out_rs1), 32'd2);
    check("addi_imm", 32'(out_imm12), 32'hFFF);
    cycle(1'b1, 32'h00512423, 1'b1, 1'b0);
    check("sw_imm", 32'(out_imm12), 32'h008);
    check("sw_rs1", 32'(out_rs1), 32'd2);
    check("sw_rs2", 32'(out_rs2), 32'd5);
    check("sw_funct3", 32'(out_funct3), 32'd2);
    check("sw_is_store", 32'(out_is_store), 32'd1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Backpressure: fill both entries, then drain in order.
    cycle(1'b1, 32'h00100093, 1'b0, 1'b0);
    cycle(1'b1, 32'h00200113, 1'b0, 1'b0);
    check("bp_in_ready_full", 32'(in_ready), 32'd0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("bp_in_ready_after", 32'(in_ready), 32'd1);
    check("bp_drained", 32'(out_valid), 32'd0);

    // Throughput: 20 back-to-back words.
    p0 = popped;
    for (int unsigned k = 0; k < 20; k++)
      cycle(1'b1, 32'h00000093 + (k << 7) + (k << 20), 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("tput_count", popped - p0, 32'd20);

    // Flush while full with a new word presented: that word is dropped.
    cycle(1'b1, 32'h00300193, 1'b0, 1'b0);
    cycle(1'b1, 32'h00400213, 1'b0, 1'b0);
    cycle(1'b1, 32'hDEAD0293, 1'b0, 1'b1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    cycle(1'b1, 32'h00600313, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    // Flush coinciding with an output handshake still consumes that word.
    p0 = popped;
    cycle(1'b1, 32'h00700393, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check("flush_consumed", popped - p0, 32'd1);
    check("flush2_out_valid", 32'(out_valid), 32'd0);

`ifdef DECODE_ILLEGAL_CHECK_EN
    cycle(1'b1, 32'h00000000, 1'b1, 1'b0);
    check("illegal_zero", 32'(out_illegal), 32'd1);
    cycle(1'b1, 32'h00000013, 1'b1, 1'b0);
    check("illegal_nop", 32'(out_illegal), 32'd0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
`endif

    // Random traffic against the model.
    for (int unsigned n = 0; n < 800; n++)
      cycle(($urandom_range(0, 3) != 0), rand_instr(), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 31) == 0));

    // Asynchronous reset with both entries occupied.
    cycle(1'b1, 32'h00812423, 1'b0, 1'b0);
    cycle(1'b1, 32'hFFF10093, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_imm12", 32'(out_imm12), 32'd0);
    check("arst_rs1", 32'(out_rs1), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 32'h00512423, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
